// File: rtl/mcu_sequencer.sv
// mcu_sequencer
// Control for the chroma supersample stage of a baseline 4:2:0 JPEG decoder.
// Accepts IDCT'd 8x8 blocks from the decode pipe and checks each channel tag
// against the MCU order Y0,Y1,Y2,Y3,Cb,Cr. In-order blocks are issued to the
// supersample stage. Issue is throttled by a downstream credit counter.
// Sideband tags are registered once, so they line up with the supersample's
// registered output.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, frame_mcus     frame start pulse and frame length (sampled on start)
//   busy                  frame in progress
//   in_valid/in_ready     upstream block handshake; in_ch is the channel tag
//   ss_valid, ss_ch       supersample valid_in / ch_in
//   credit_return         downstream freed one buffer slot
//   out_tag_valid, out_y_idx, out_mcu_last, out_frame_last
//                         sideband tags, one cycle after issue
//   mcu_count             MCUs completed in the current frame
//   order_err, err_clear  sticky order/credit error and its clear
module mcu_sequencer #(
    parameter int CREDITS = 2,
    parameter int MCU_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [MCU_W-1:0] frame_mcus,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_ch,
    output logic             ss_valid,
    output logic [1:0]       ss_ch,
    input  logic             credit_return,
    output logic             out_tag_valid,
    output logic [1:0]       out_y_idx,
    output logic             out_mcu_last,
    output logic             out_frame_last,
    output logic [MCU_W-1:0] mcu_count,
    output logic             order_err,
    input  logic             err_clear
);

    localparam logic [3:0] CRED_MAX = 4'(CREDITS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_Y    = 2'd1,
        ST_CB   = 2'd2,
        ST_CR   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       y_cnt_q, y_cnt_d;
    logic [3:0]       credits_q, credits_d;
    logic [MCU_W-1:0] mcu_count_q, mcu_count_d;
    logic [MCU_W-1:0] frame_len_q, frame_len_d;
    logic             order_err_q, order_err_d;
    logic             tag_valid_q, tag_valid_d;
    logic [1:0]       tag_y_idx_q, tag_y_idx_d;
    logic             tag_mcu_last_q, tag_mcu_last_d;
    logic             tag_frame_last_q, tag_frame_last_d;

    logic             busy_c;
    logic [1:0]       exp_ch;
    logic             ready_c;
    logic             accept;
    logic             issue;
    logic             mismatch;
    logic             overflow;
    logic [MCU_W-1:0] mcu_inc;
    logic             last_mcu;

    always_comb begin
        busy_c   = (state_q != ST_IDLE);
        exp_ch   = 2'd0;
        case (state_q)
            ST_Y:    exp_ch = 2'd0;
            ST_CB:   exp_ch = 2'd1;
            ST_CR:   exp_ch = 2'd2;
            default: exp_ch = 2'd0;
        endcase
        ready_c  = busy_c && (credits_q != 4'd0);
        accept   = in_valid && ready_c;
        issue    = accept && (in_ch == exp_ch);
        mismatch = accept && (in_ch != exp_ch);
        // A return that coincides with an issue is net zero, so it can never
        // overflow; only a lone return into a full counter is an error.
        overflow = credit_return && !issue && (credits_q == CRED_MAX);
        mcu_inc  = mcu_count_q + 1'b1;
        last_mcu = !(mcu_inc < frame_len_q);
    end

    always_comb begin
        state_d          = state_q;
        y_cnt_d          = y_cnt_q;
        credits_d        = credits_q;
        mcu_count_d      = mcu_count_q;
        frame_len_d      = frame_len_q;
        order_err_d      = order_err_q;
        tag_valid_d      = issue;
        tag_y_idx_d      = 2'd0;
        tag_mcu_last_d   = 1'b0;
        tag_frame_last_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && (frame_mcus != '0)) begin
                    state_d     = ST_Y;
                    frame_len_d = frame_mcus;
                    mcu_count_d = '0;
                    y_cnt_d     = 2'd0;
                end
            end
            ST_Y: begin
                if (issue) begin
                    tag_y_idx_d = y_cnt_q;
                    if (y_cnt_q == 2'd3) begin
                        state_d = ST_CB;
                        y_cnt_d = 2'd0;
                    end else begin
                        y_cnt_d = y_cnt_q + 2'd1;
                    end
                end
            end
            ST_CB: begin
                if (issue) begin
                    state_d = ST_CR;
                end
            end
            ST_CR: begin
                if (issue) begin
                    tag_mcu_last_d   = 1'b1;
                    tag_frame_last_d = last_mcu;
                    mcu_count_d      = mcu_inc;
                    y_cnt_d          = 2'd0;
                    state_d          = last_mcu ? ST_IDLE : ST_Y;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (issue && !credit_return) begin
            credits_d = credits_q - 4'd1;
        end else if (credit_return && !issue && (credits_q != CRED_MAX)) begin
            credits_d = credits_q + 4'd1;
        end

        // Setting wins over clearing in the same cycle.
        if (mismatch || overflow) begin
            order_err_d = 1'b1;
        end else if (err_clear) begin
            order_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            y_cnt_q          <= 2'd0;
            credits_q        <= CRED_MAX;
            mcu_count_q      <= '0;
            frame_len_q      <= '0;
            order_err_q      <= 1'b0;
            tag_valid_q      <= 1'b0;
            tag_y_idx_q      <= 2'd0;
            tag_mcu_last_q   <= 1'b0;
            tag_frame_last_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            y_cnt_q          <= y_cnt_d;
            credits_q        <= credits_d;
            mcu_count_q      <= mcu_count_d;
            frame_len_q      <= frame_len_d;
            order_err_q      <= order_err_d;
            tag_valid_q      <= tag_valid_d;
            tag_y_idx_q      <= tag_y_idx_d;
            tag_mcu_last_q   <= tag_mcu_last_d;
            tag_frame_last_q <= tag_frame_last_d;
        end
    end

    assign busy           = busy_c;
    assign in_ready       = ready_c;
    assign ss_valid       = issue;
    assign ss_ch          = exp_ch;
    assign out_tag_valid  = tag_valid_q;
    assign out_y_idx      = tag_y_idx_q;
    assign out_mcu_last   = tag_mcu_last_q;
    assign out_frame_last = tag_frame_last_q;
    assign mcu_count      = mcu_count_q;
    assign order_err      = order_err_q;

endmodule

// File: tb/tb_mcu_sequencer.sv
// Randomised bench for mcu_sequencer. The reference model tracks the block
// position inside the frame as one integer and derives the expected channel,
// Y index and MCU boundaries from it with plain arithmetic.
module tb_mcu_sequencer;

    localparam int C     = 2;
    localparam int MCU_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [MCU_W-1:0] frame_mcus;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_ch;
    logic             ss_valid;
    logic [1:0]       ss_ch;
    logic             credit_return;
    logic             out_tag_valid;
    logic [1:0]       out_y_idx;
    logic             out_mcu_last;
    logic             out_frame_last;
    logic [MCU_W-1:0] mcu_count;
    logic             order_err;
    logic             err_clear;

    mcu_sequencer #(.CREDITS(C), .MCU_W(MCU_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .frame_mcus(frame_mcus),
        .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
        .ss_valid(ss_valid), .ss_ch(ss_ch), .credit_return(credit_return),
        .out_tag_valid(out_tag_valid), .out_y_idx(out_y_idx),
        .out_mcu_last(out_mcu_last), .out_frame_last(out_frame_last),
        .mcu_count(mcu_count), .order_err(order_err), .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int m_busy, m_pos, m_len, m_mcu, m_cred, m_err;
    int e_tv, e_yidx, e_ml, e_fl;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int chan_of(input int pos);
        int k = pos % 6;
        return (k < 4) ? 0 : (k == 4 ? 1 : 2);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_pos = 0; m_len = 0; m_mcu = 0; m_cred = C; m_err = 0;
        e_tv = 0; e_yidx = 0; e_ml = 0; e_fl = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rdy"}, in_ready, 0);
        check({tag, "_ssv"}, ss_valid, 0);
        check({tag, "_ssch"}, ss_ch, 0);
        check({tag, "_tv"}, out_tag_valid, 0);
        check({tag, "_yidx"}, out_y_idx, 0);
        check({tag, "_ml"}, out_mcu_last, 0);
        check({tag, "_fl"}, out_frame_last, 0);
        check({tag, "_mcu"}, mcu_count, 0);
        check({tag, "_err"}, order_err, 0);
    endtask

    // Inputs are already driven (just after a falling edge). Check the
    // combinational outputs, advance the model, then check registered state.
    task automatic cycle();
        int ech, rdy, acc, iss, k, lastm, ovf;
        #1;
        ech = m_busy ? chan_of(m_pos) : 0;
        rdy = (m_busy != 0 && m_cred != 0) ? 1 : 0;
        acc = (in_valid && rdy) ? 1 : 0;
        iss = (acc && in_ch == ech) ? 1 : 0;
        check("in_ready", in_ready, rdy);
        check("ss_valid", ss_valid, iss);
        check("ss_ch", ss_ch, ech);
        check("busy", busy, m_busy);

        k     = m_pos % 6;
        lastm = (m_pos / 6 + 1 >= m_len) ? 1 : 0;
        e_tv   = iss;
        e_yidx = (iss && k < 4) ? k : 0;
        e_ml   = (iss && k == 5) ? 1 : 0;
        e_fl   = (e_ml && lastm) ? 1 : 0;

        ovf = (credit_return && !iss && m_cred == C) ? 1 : 0;
        if ((acc && !iss) || ovf) m_err = 1;
        else if (err_clear) m_err = 0;

        if (iss && !credit_return) m_cred--;
        else if (credit_return && !iss && m_cred < C) m_cred++;

        if (!m_busy) begin
            if (start && frame_mcus != 0) begin
                m_busy = 1; m_len = frame_mcus; m_pos = 0; m_mcu = 0;
            end
        end else if (iss) begin
            if (k == 5) begin
                m_mcu = (m_mcu + 1) % (1 << MCU_W);
                if (lastm) m_busy = 0;
                else m_pos++;
            end else begin
                m_pos++;
            end
        end

        @(posedge clk);
        #1;
        check("tag_valid", out_tag_valid, e_tv);
        check("y_idx", out_y_idx, e_yidx);
        check("mcu_last", out_mcu_last, e_ml);
        check("frame_last", out_frame_last, e_fl);
        check("mcu_count", mcu_count, m_mcu);
        check("busy_q", busy, m_busy);
        check("order_err", order_err, m_err);
        $display("cyc t=%0t v=%0d ch=%0d rdy=%0d ssv=%0d ssch=%0d tv=%0d y=%0d ml=%0d fl=%0d mcu=%0d err=%0d",
                 $time, in_valid, in_ch, in_ready, ss_valid, ss_ch, out_tag_valid,
                 out_y_idx, out_mcu_last, out_frame_last, mcu_count, order_err);
        @(negedge clk);
    endtask

    task automatic drive_idle();
        start = 0; frame_mcus = 0; in_valid = 0; in_ch = 0;
        credit_return = 0; err_clear = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        model_reset();
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // zero-length frame start is a no-op
        start = 1; frame_mcus = 0;
        cycle();
        drive_idle();
        cycle();

        // ordered two-MCU frame with prompt credit return
        start = 1; frame_mcus = 2;
        cycle();
        start = 0;
        for (int i = 0; i < 40 && (m_busy != 0); i++) begin
            in_valid      = 1;
            in_ch         = 2'(chan_of(m_pos));
            credit_return = (m_cred < C) ? 1'b1 : 1'b0;
            cycle();
        end
        check("frame2_done_busy", busy, 0);
        check("frame2_mcu", mcu_count, 2);
        drive_idle();

        for (int cyc = 0; cyc < 4000; cyc++) begin
            int ech;
            ech        = m_busy ? chan_of(m_pos) : 0;
            start      = ($urandom_range(0, 15) == 0);
            frame_mcus = MCU_W'($urandom_range(0, 3));
            in_valid   = ($urandom_range(0, 3) != 0);
            in_ch      = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'(ech);
            err_clear  = ($urandom_range(0, 15) == 0);
            if (cyc >= 1500 && cyc < 1700)
                credit_return = 0;  // credit starvation window
            else if (m_cred < C)
                credit_return = ($urandom_range(0, 2) != 0);
            else
                credit_return = ($urandom_range(0, 29) == 0);

            if ((cyc % 700) == 350 && m_busy != 0) begin
                // asynchronous reset mid-frame, with a block offered
                rst_n = 1'b0;
                #1;
                check_all_zero("midrst");
                model_reset();
                @(posedge clk);
                #1;
                check("midrst_tv", out_tag_valid, 0);
                check("midrst_rdy", in_ready, 0);
                @(negedge clk);
                rst_n = 1'b1;
                drive_idle();
            end else begin
                cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mcu_sequencer.md
Name: mcu_sequencer

Overview:
- Controls the chroma supersample stage for baseline 4:2:0 JPEG decode.
- Accepts dequantised, IDCT'd 8x8 blocks from the decode pipe with a valid/ready handshake. Checks each block's channel tag against the expected MCU order Y0,Y1,Y2,Y3,Cb,Cr.
- Drives the supersample valid and channel inputs. Throttles issue with a downstream credit counter.
- Emits sideband tags (Y index, MCU-last, frame-last) aligned to the supersample's registered output. Counts MCUs per frame.

Parameters:
- CREDITS, 2, downstream buffer slots; initial and maximum credit count (1..15).
- MCU_W, 16, width of the MCU count and frame-length fields.

Ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- start  in  1  one-cycle pulse; begins a frame; ignored while busy.
- frame_mcus  in  MCU_W  MCUs in the frame; sampled on start.
- busy  out  1  frame in progress.
- in_valid  in  1  upstream block valid.
- in_ready  out  1  upstream block accepted this cycle when in_valid is also high.
- in_ch  in  2  upstream channel tag: 0=Y, 1=Cb, 2=Cr.
- ss_valid  out  1  to supersample valid_in.
- ss_ch  out  2  to supersample ch_in.
- credit_return  in  1  downstream freed one slot.
- out_tag_valid  out  1  aligned with the supersample valid_out being nonzero.
- out_y_idx  out  2  Y block index 0..3 for Y outputs; 0 for chroma.
- out_mcu_last  out  1  output is the Cr of an MCU.
- out_frame_last  out  1  output is the Cr of the final MCU.
- mcu_count  out  MCU_W  MCUs completed in the current frame.
- order_err  out  1  sticky: tag mismatch or credit overflow.
- err_clear  in  1  clears order_err.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, y_cnt=0, credits=CREDITS, mcu_count=0.
  - busy, in_ready, ss_valid, all out_* outputs, and order_err are 0.
  - ss_ch=0.
- States and transitions:
  - IDLE -> Y on start with frame_mcus != 0. Latch frame_mcus, clear mcu_count.
  - start with frame_mcus=0: stay IDLE, no pulses.
  - Y -> Y on each issued Y block while y_cnt<3; y_cnt increments.
  - Y -> CB on the issued Y block with y_cnt=3.
  - CB -> CR on the issued Cb block.
  - CR -> Y on the issued Cr block (y_cnt=0, mcu_count+1) if mcu_count+1 < latched frame_mcus. Otherwise CR -> IDLE.
  - busy = (state != IDLE).
- Expected channel:
  - Y state: 0; CB state: 1; CR state: 2.
  - ss_ch is driven with the expected channel every non-IDLE cycle; 0 in IDLE.
- Handshake (combinational):
  - in_ready = busy && credits != 0.
  - accept = in_valid && in_ready.
  - ss_valid = accept && (in_ch == expected channel).
  - Block data goes straight from upstream to the supersample; this block carries only control.
- Mismatch:
  - accept with a wrong in_ch consumes and drops the block.
  - ss_valid stays 0, state and counters do not change, credit is not consumed.
  - order_err sets on the next edge.
- Credits:
  - Decrement on ss_valid; increment on credit_return.
  - Both in one cycle: unchanged.
  - credit_return when credits==CREDITS: ignored and sets order_err.
  - credits==0: in_ready=0, upstream stalls, and no issue occurs.
- Tag pipeline (one register stage, matching the supersample's 1-cycle registered output):
  - out_tag_valid <= ss_valid.
  - out_y_idx <= y_cnt in Y state, else 0.
  - out_mcu_last <= ss_valid in CR.
  - out_frame_last <= out_mcu_last condition && this is the final MCU.
  - Every tag is 0 in cycles where out_tag_valid is 0.
- Latency: accepted block -> supersample outputs plus tags = 1 cycle.
- End of frame:
  - mcu_count increments on the edge of the Cr issue and wraps at 2^MCU_W.
  - mcu_count holds its final value in IDLE until the next valid start.
- start while busy: ignored; the latched length is unchanged.
- order_err:
  - Set has priority over err_clear in the same cycle.
  - The error does not halt sequencing.
- Reset mid-frame: everything returns to reset values immediately. No tag is emitted for a block accepted in the reset cycle.

Test Plan:
- start, frame_mcus=2, CREDITS=2, credit_return pulsed each cycle after out_tag_valid, 12 in-order blocks -> ss_ch sequence 0,0,0,0,1,2,0,0,0,0,1,2. out_y_idx=0,1,2,3 on the Y tags. out_mcu_last on tags 6 and 12, out_frame_last only on tag 12. mcu_count=2, busy drops the cycle after the 12th accept.
- No credit_return, CREDITS=2, continuous in_valid -> exactly 2 accepts, then in_ready=0. One credit_return pulse -> exactly one more accept.
- In Y state with y_cnt=1, present in_ch=1 -> block accepted with ss_valid=0 and order_err=1. The next in_ch=0 block is issued with out_y_idx=1.
- Simultaneous ss_valid and credit_return with credits=1 -> credits stays 1. credit_return at credits=2 -> order_err=1, credits stays 2.
- start with frame_mcus=0 -> busy stays 0, in_ready 0. start during busy -> ignored, frame still ends after the original count.
- Assert rst_n low mid-MCU (state CB) -> all outputs 0 at once and credits=2. After release plus start, the sequence restarts at Y0.
